// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and types for the register bank slice.
//   DEF_WIDTH / DEF_ADDR_WIDTH / DEF_SP_INIT : default bank geometry
//   ZERO_REG : hard-wired zero register index
//   SP_IDX   : index of the stack-pointer register for the default depth
//   reg_addr_t : register address type for the default geometry
package reg_bank_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam logic [DEF_WIDTH-1:0] DEF_SP_INIT = 32'h0000_03FF;
  localparam int ZERO_REG       = 0;
  localparam int SP_IDX         = (2 ** DEF_ADDR_WIDTH) - 1;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// reg_bank_scoreboard: per-register pending-write tracker.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_addr    : write-back event, clears the target's busy bit
//   rsv_en, rsv_addr  : reservation request, sets the target's busy bit
//   busy              : current busy vector (bit 0 is never set)
//   rsv_ack           : registered, reservation accepted last cycle
//   busy_cnt          : number of registers currently pending
module reg_bank_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic                          rsv_en,
  input  logic [ADDR_WIDTH-1:0]         rsv_addr,
  output logic [(2**ADDR_WIDTH)-1:0]    busy,
  output logic                          rsv_ack,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]    busy_reg, busy_next;
  logic                rsv_ack_reg;
  logic [ADDR_WIDTH:0] busy_cnt_reg, busy_cnt_next;
  logic                wr_nz, rsv_nz;
  logic                wr_clr, rsv_ok, rsv_set;

  assign wr_nz  = (wr_addr  != ADDR_WIDTH'(ZERO_REG));
  assign rsv_nz = (rsv_addr != ADDR_WIDTH'(ZERO_REG));

  always_comb begin
    // A clear only counts if the bit was actually set.
    wr_clr  = wr_en && wr_nz && busy_reg[wr_addr];
    // A same-cycle write to the reserved register frees it first, so the
    // reservation sees it idle. Reservations of register 0 are acked but inert.
    rsv_ok  = rsv_en && (!rsv_nz || !busy_reg[rsv_addr] ||
                         (wr_en && (wr_addr == rsv_addr)));
    rsv_set = rsv_ok && rsv_nz;

    busy_next = busy_reg;
    if (wr_en && wr_nz) busy_next[wr_addr] = 1'b0;
    if (rsv_set)        busy_next[rsv_addr] = 1'b1;

    // Set and clear in one cycle cancel; bit 0 is excluded so the count
    // tops out at DEPTH-1 and cannot wrap.
    busy_cnt_next = busy_cnt_reg + (ADDR_WIDTH+1)'(rsv_set)
                                 - (ADDR_WIDTH+1)'(wr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg     <= '0;
      rsv_ack_reg  <= 1'b0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      rsv_ack_reg  <= rsv_ok;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy     = busy_reg;
  assign rsv_ack  = rsv_ack_reg;
  assign busy_cnt = busy_cnt_reg;

endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: parametrised multi-read / single-write register bank with
// registered reads, optional write-to-read bypass and a pending-write
// scoreboard for load-use stalls.
// Optional feature macro: REG_BANK_SB_BYPASS_EN (read of a register being
// written in the same cycle returns wr_data and reports not-busy).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_en[NUM_RD]       : per-port read enable
//   rd_addr, rd_data    : packed per-port address / registered data
//   rd_busy[NUM_RD]     : registered, register was pending at read time
//   wr_en/wr_addr/wr_data : write-back port
//   rsv_en/rsv_addr     : reservation request
//   rsv_ack             : registered reservation accept
//   busy_cnt            : number of pending registers
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter logic [WIDTH-1:0] SP_INIT = DEF_SP_INIT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         rsv_ack,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int TOP_IDX = DEPTH - 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] sb_busy;
  logic             wr_nz;

  assign wr_nz = (wr_addr != ADDR_WIDTH'(ZERO_REG));

  // Storage: reset value needed for the stack pointer rules out a plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= (i == TOP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_en && wr_nz) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  reg_bank_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (sb_busy),
    .rsv_ack  (rsv_ack),
    .busy_cnt (busy_cnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic                  addr_nz;
      logic                  hit;
      logic [WIDTH-1:0]      data_reg, data_next;
      logic                  busy_reg, busy_next;

      assign addr    = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign addr_nz = (addr != ADDR_WIDTH'(ZERO_REG));

`ifdef REG_BANK_SB_BYPASS_EN
      assign hit = wr_en && wr_nz && (wr_addr == addr);
`else
      // Without bypass the port sees the pre-edge value and busy bit.
      assign hit = 1'b0;
`endif

      always_comb begin
        data_next = '0;
        busy_next = 1'b0;
        if (rd_en[gi] && addr_nz) begin
          if (hit) begin
            data_next = wr_data;
          end else begin
            data_next = mem_reg[addr];
            busy_next = sb_busy[addr];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          data_reg <= data_next;
          busy_reg <= busy_next;
        end
      end

      assign rd_data[gi*WIDTH +: WIDTH] = data_reg;
      assign rd_busy[gi]                = busy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb: table-driven directed vectors, a mid-cycle reset sequence
// and a randomized phase checked against an array-based model.
module tb_reg_bank_sb;
  import reg_bank_pkg::*;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2 ** AW;
`ifdef REG_BANK_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*W-1:0]   rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ack;
  logic [AW:0]       busy_cnt;

  always #5 clk = ~clk;

  reg_bank_sb #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .NUM_RD     (NR),
    .SP_INIT    (32'h0000_03FF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ack  (rsv_ack),
    .busy_cnt (busy_cnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  rd_en;
    logic [4:0]  a0, a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [31:0] x0, x1;
    logic [1:0]  xb;
    logic        xa;
    logic [5:0]  xc;
  } vec_t;

  vec_t vecs [20];

  // Reference model: plain arrays updated from the behavioural rules.
  logic [W-1:0] m_reg  [DEPTH];
  bit           m_busy [DEPTH];
  logic [W-1:0] e_rd   [NR];
  bit           e_bsy  [NR];
  bit           e_ack;
  int           e_cnt;

  function automatic vec_t mk(logic [1:0] re_n, logic [4:0] a0, logic [4:0] a1,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic rs, logic [4:0] ra,
                              logic [31:0] x0, logic [31:0] x1, logic [1:0] xb,
                              logic xa, logic [5:0] xc);
    vec_t v;
    v.rd_en = re_n; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd;
    v.re = rs; v.ra = ra; v.x0 = x0; v.x1 = x1; v.xb = xb; v.xa = xa; v.xc = xc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_reg[SP_IDX] = 32'h0000_03FF;
  endtask

  // Computes expected outputs for the upcoming edge from current inputs,
  // then advances the model state.
  task automatic model_step();
    reg_addr_t a;
    int c;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      e_rd[p]  = '0;
      e_bsy[p] = 1'b0;
      if (rd_en[p] && a != 0) begin
        if (BYP && wr_en && wr_addr == a) begin
          e_rd[p] = wr_data;
        end else begin
          e_rd[p]  = m_reg[a];
          e_bsy[p] = m_busy[a];
        end
      end
    end
    e_ack = rsv_en && (rsv_addr == 0 || !m_busy[rsv_addr] ||
                       (wr_en && wr_addr == rsv_addr));
    if (wr_en && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (e_ack && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    e_cnt = c;
  endtask

  initial begin
    vecs[0]  = mk(2'b11, 31, 5,  0, 0, 0,            0, 0,  32'h3FF, 0, 2'b00, 0, 0);
    vecs[1]  = mk(2'b00, 0,  0,  1, 3, 32'hDEADBEEF, 0, 0,  0, 0, 2'b00, 0, 0);
    vecs[2]  = mk(2'b01, 3,  0,  1, 0, 5,            0, 0,  32'hDEADBEEF, 0, 2'b00, 0, 0);
    vecs[3]  = mk(2'b01, 0,  0,  0, 0, 0,            0, 0,  0, 0, 2'b00, 0, 0);
    vecs[4]  = mk(2'b01, 7,  0,  1, 7, 32'h1234,     0, 0,  BYP ? 32'h1234 : 32'h0, 0, 2'b00, 0, 0);
    vecs[5]  = mk(2'b01, 7,  0,  0, 0, 0,            0, 0,  32'h1234, 0, 2'b00, 0, 0);
    vecs[6]  = mk(2'b00, 0,  0,  0, 0, 0,            1, 4,  0, 0, 2'b00, 1, 1);
    vecs[7]  = mk(2'b10, 0,  4,  0, 0, 0,            0, 0,  0, 0, 2'b10, 0, 1);
    vecs[8]  = mk(2'b00, 0,  0,  0, 0, 0,            1, 4,  0, 0, 2'b00, 0, 1);
    vecs[9]  = mk(2'b00, 0,  0,  1, 4, 9,            0, 0,  0, 0, 2'b00, 0, 0);
    vecs[10] = mk(2'b01, 4,  0,  0, 0, 0,            0, 0,  9, 0, 2'b00, 0, 0);
    vecs[11] = mk(2'b00, 0,  0,  1, 6, 2,            1, 6,  0, 0, 2'b00, 1, 1);
    vecs[12] = mk(2'b11, 6,  6,  0, 0, 0,            0, 0,  2, 2, 2'b11, 0, 1);
    vecs[13] = mk(2'b00, 0,  0,  0, 0, 0,            1, 0,  0, 0, 2'b00, 1, 1);
    vecs[14] = mk(2'b01, 6,  0,  1, 6, 77,           0, 0,  BYP ? 32'd77 : 32'd2, 0,
                  BYP ? 2'b00 : 2'b01, 0, 0);
    vecs[15] = mk(2'b01, 8,  0,  0, 0, 0,            1, 8,  0, 0, 2'b00, 1, 1);
    vecs[16] = mk(2'b01, 8,  0,  0, 0, 0,            0, 0,  0, 0, 2'b01, 0, 1);
    vecs[17] = mk(2'b00, 0,  0,  0, 0, 0,            1, 2,  0, 0, 2'b00, 1, 2);
    vecs[18] = mk(2'b00, 0,  0,  0, 0, 0,            1, 9,  0, 0, 2'b00, 1, 3);
    vecs[19] = mk(2'b01, 31, 0,  0, 0, 0,            1, 10, 32'h3FF, 0, 2'b00, 1, 4);

    idle_inputs();
    #2 rst_n = 1'b0;
    cycle();
    cycle();
    check("reset_rd_data", rd_data, 64'h0);
    check("reset_rd_busy", rd_busy, 0);
    check("reset_rsv_ack", rsv_ack, 0);
    check("reset_busy_cnt", busy_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 20; i++) begin
      rd_en = vecs[i].rd_en; rd_addr = {vecs[i].a1, vecs[i].a0};
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rsv_en = vecs[i].re; rsv_addr = vecs[i].ra;
      cycle();
      $display("vec %0d rd0=%h rd1=%h busy=%b ack=%b cnt=%0d",
               i, rd_data[31:0], rd_data[63:32], rd_busy, rsv_ack, busy_cnt);
      check($sformatf("vec%0d_rd0", i), rd_data[31:0], vecs[i].x0);
      check($sformatf("vec%0d_rd1", i), rd_data[63:32], vecs[i].x1);
      check($sformatf("vec%0d_busy", i), rd_busy, vecs[i].xb);
      check($sformatf("vec%0d_ack", i), rsv_ack, vecs[i].xa);
      check($sformatf("vec%0d_cnt", i), busy_cnt, vecs[i].xc);
    end

    // Mid-cycle asynchronous reset with live outputs and pending entries.
    idle_inputs();
    #3 rst_n = 1'b0;
    #1;
    $display("midreset rd=%h busy=%b ack=%b cnt=%0d", rd_data, rd_busy, rsv_ack, busy_cnt);
    check("midreset_rd_data", rd_data, 64'h0);
    check("midreset_rd_busy", rd_busy, 0);
    check("midreset_rsv_ack", rsv_ack, 0);
    check("midreset_busy_cnt", busy_cnt, 0);
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    rd_en = 2'b11; rd_addr = {5'd3, 5'd31};
    cycle();
    $display("postreset rd0=%h rd1=%h busy=%b", rd_data[31:0], rd_data[63:32], rd_busy);
    check("postreset_sp", rd_data[31:0], 32'h3FF);
    check("postreset_r3", rd_data[63:32], 32'h0);
    check("postreset_busy", rd_busy, 0);

    rd_en = 2'b01; rd_addr = {5'd0, 5'd2}; rsv_en = 1'b1; rsv_addr = 5'd2;
    model_step();
    cycle();
    $display("postreset_rsv ack=%b cnt=%0d busy=%b", rsv_ack, busy_cnt, rd_busy);
    check("postreset_rsv_ack", rsv_ack, 1);
    check("postreset_rsv_cnt", busy_cnt, 1);
    check("postreset_rd_busy", rd_busy, 0);

    for (int t = 0; t < 400; t++) begin
      rd_en = NR'($urandom);
      for (int p = 0; p < NR; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 1) == 0);
      rsv_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      model_step();
      cycle();
      $display("rnd %0d rd0=%h rd1=%h busy=%b ack=%b cnt=%0d",
               t, rd_data[31:0], rd_data[63:32], rd_busy, rsv_ack, busy_cnt);
      check("rnd_rd0", rd_data[31:0], e_rd[0]);
      check("rnd_rd1", rd_data[63:32], e_rd[1]);
      check("rnd_busy0", rd_busy[0], e_bsy[0]);
      check("rnd_busy1", rd_busy[1], e_bsy[1]);
      check("rnd_ack", rsv_ack, e_ack);
      check("rnd_cnt", busy_cnt, e_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
